serial_rx_package: RTL and testbench



---
 rtl/serial_pkg.sv | 13 +
 rtl/serial_rx_frame.sv | 113 +++++++++++
 rtl/serial_rx_package.sv | 87 ++++++++
 tb/tb_serial_rx_package.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared serial framing types, constants and bit-period helper
package serial_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} serial_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int bit_period(input int timer_width);
    return 1 << timer_width;
  endfunction

endpackage

// File: rtl/serial_rx_frame.sv
// rtl/serial_rx_frame.sv - 8N1 frame receiver: rx synchronizer, bit timer, START/DATA/STOP FSM
module serial_rx_frame
  import serial_pkg::*;
#(
  parameter int WordWidth        = 8,
  parameter int SerialTimerWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [WordWidth-1:0] word,
  output logic                 word_valid,
  output logic                 stop_error,
  output logic                 idle,
  output logic                 start_edge
);

  localparam int P  = bit_period(SerialTimerWidth);
  localparam int CW = (WordWidth > 1) ? $clog2(WordWidth) : 1;
  localparam logic [SerialTimerWidth:0] TIMER_FULL = (SerialTimerWidth + 1)'(P);
  localparam logic [SerialTimerWidth:0] TIMER_HALF = (SerialTimerWidth + 1)'(P / 2);
  localparam logic [SerialTimerWidth:0] TIMER_ONE  = (SerialTimerWidth + 1)'(1);

  serial_state_t             state, state_next;
  logic                      rx_meta, rxs, rxs_d;
  logic [SerialTimerWidth:0] timer;
  logic [CW-1:0]             bit_cnt;
  logic                      fall, expire, load_half, load_full, shift_en;

  assign fall       = rxs_d & ~rxs;
  assign expire     = (timer == TIMER_ONE);
  assign idle       = (state == IDLE);
  assign start_edge = idle & fall;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_half  = 1'b0;
    load_full  = 1'b0;
    shift_en   = 1'b0;
    word_valid = 1'b0;
    stop_error = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_next = START;
          load_half  = 1'b1;
        end
      end
      START: begin
        if (expire) begin
          if (rxs == START_BIT) begin
            state_next = DATA;
            load_full  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (bit_cnt == CW'(WordWidth - 1)) state_next = STOP;
        end
      end
      STOP: begin
        if (expire) begin
          state_next = IDLE;
          if (rxs == STOP_BIT) word_valid = 1'b1;
          else                 stop_error = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Timer counts down to 1; the sample happens on the cycle it reads 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      bit_cnt <= '0;
      word    <= '0;
    end else begin
      if (load_half)          timer <= TIMER_HALF;
      else if (load_full)     timer <= TIMER_FULL;
      else if (timer != '0)   timer <= timer - TIMER_ONE;

      if (state == START)     bit_cnt <= '0;
      else if (shift_en)      bit_cnt <= bit_cnt + CW'(1);

      if (shift_en)           word <= {rxs, word[WordWidth-1:1]};
    end
  end

endmodule

// File: rtl/serial_rx_package.sv
// rtl/serial_rx_package.sv - assembles 2**AddressWidth serial words into one wide package on Q
module serial_rx_package
  import serial_pkg::*;
#(
  parameter int WordWidth        = 8,
  parameter int AddressWidth     = 3,
  parameter int SerialTimerWidth = 8,
  parameter int TimeoutBits      = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rx,
  output logic [WordWidth*(2**AddressWidth)-1:0] Q,
  output logic                                 finish,
  output logic                                 busy,
  output logic                                 frameError
);

  localparam int Words    = 2 ** AddressWidth;
  localparam int QW       = WordWidth * Words;
  localparam int ToCycles = TimeoutBits * bit_period(SerialTimerWidth);
  localparam int ToW      = $clog2(ToCycles + 1);

  logic [WordWidth-1:0]    word;
  logic                    word_valid, stop_error, idle, start_edge;
  logic [AddressWidth-1:0] index;
  logic [QW-1:0]           stage, stage_wr;
  logic [ToW-1:0]          to_cnt;
  logic                    timeout_hit, last_word;

  serial_rx_frame #(
    .WordWidth       (WordWidth),
    .SerialTimerWidth(SerialTimerWidth)
  ) u_frame (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .word      (word),
    .word_valid(word_valid),
    .stop_error(stop_error),
    .idle      (idle),
    .start_edge(start_edge)
  );

  // Slot 0 (first word received) occupies the most significant bits.
  always_comb begin
    stage_wr = stage;
    stage_wr[(Words - 1 - int'(index)) * WordWidth +: WordWidth] = word;
  end

  assign last_word   = (index == AddressWidth'(Words - 1));
  assign timeout_hit = idle && (index != '0) && !start_edge && (to_cnt == ToW'(ToCycles - 1));
  assign busy        = (index != '0) || !idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q          <= '0;
      finish     <= 1'b0;
      frameError <= 1'b0;
      index      <= '0;
      stage      <= '0;
      to_cnt     <= '0;
    end else begin
      finish     <= 1'b0;
      frameError <= stop_error | timeout_hit;

      // A start edge on the expiry cycle suppresses the abort and clears the count.
      if (idle && (index != '0) && !start_edge && !timeout_hit) to_cnt <= to_cnt + ToW'(1);
      else                                                      to_cnt <= '0;

      if (word_valid) begin
        stage <= stage_wr;
        if (last_word) begin
          Q      <= stage_wr;
          finish <= 1'b1;
          index  <= '0;
        end else begin
          index  <= index + AddressWidth'(1);
        end
      end else if (stop_error || timeout_hit) begin
        index <= '0;
        stage <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_package.sv
// tb/tb_serial_rx_package.sv - self-checking bench for serial_rx_package against a word-list package model
module tb_serial_rx_package;

  localparam int WW  = 8;
  localparam int AW  = 3;
  localparam int STW = 4;
  localparam int TOB = 4;
  localparam int P   = 16;
  localparam int NW  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [63:0] Q;
  logic        finish, busy, frameError;

  serial_rx_package #(
    .WordWidth       (WW),
    .AddressWidth    (AW),
    .SerialTimerWidth(STW),
    .TimeoutBits     (TOB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .Q         (Q),
    .finish    (finish),
    .busy      (busy),
    .frameError(frameError)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_fin  = 0;
  int n_err  = 0;
  int cyc    = 0;
  logic [63:0] got_q[$];
  int          fin_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (finish) begin
        got_q.push_back(Q);
        fin_cyc.push_back(cyc);
        n_fin++;
      end
      if (frameError) n_err++;
    end
  end

  // Reference model: list of accepted words; a full list becomes a package.
  logic [7:0]  cur[$];
  logic [63:0] exp_q[$];
  logic [63:0] exp_last = '0;
  int          exp_fin  = 0;
  int          exp_err  = 0;

  task automatic model_frame(input logic [7:0] b, input bit ok);
    logic [63:0] v;
    if (!ok) begin
      exp_err++;
      cur.delete();
    end else begin
      cur.push_back(b);
      if (cur.size() == NW) begin
        v = '0;
        for (int i = 0; i < NW; i++) v = {v[55:0], cur[i]};
        exp_q.push_back(v);
        exp_last = v;
        exp_fin++;
        cur.delete();
      end
    end
  endtask

  // Gaps are idle cycles after the end of a stop bit; a partial package aborts once the gap reaches TOB*P.
  task automatic model_gap(input int n);
    if (n >= TOB * P && cur.size() != 0) begin
      exp_err++;
      cur.delete();
    end
  endtask

  task automatic model_reset();
    cur.delete();
    exp_q.delete();
    exp_last = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    wait_cycles(P);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok);
    bit_time(1'b0);
    for (int i = 0; i < WW; i++) bit_time(b[i]);
    bit_time(ok);
    rx = 1'b1;
    model_frame(b, ok);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    wait_cycles(n);
    model_gap(n);
  endtask

  task automatic sync_check(input string tag);
    check({tag, ".finish_count"}, 64'(n_fin), 64'(exp_fin));
    check({tag, ".error_count"}, 64'(n_err), 64'(exp_err));
    check({tag, ".q"}, Q, exp_last);
    check({tag, ".busy"}, {63'd0, busy}, {63'd0, cur.size() != 0});
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, ".pkg"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int f0;
    logic [7:0] b;
    rst = 1'b1;
    rx  = 1'b1;
    wait_cycles(3);
    check("reset.q", Q, 64'd0);
    check("reset.finish", {63'd0, finish}, 64'd0);
    check("reset.busy", {63'd0, busy}, 64'd0);
    check("reset.frame_error", {63'd0, frameError}, 64'd0);
    rst = 1'b0;
    wait_cycles(P);

    send_frame(8'h01, 1'b1);
    sync_check("pkg1_first");
    for (int i = 2; i <= 8; i++) send_frame(8'(i), 1'b1);
    sync_check("pkg1");

    rx = 1'b0;
    wait_cycles(5);
    idle(2 * P);
    sync_check("glitch");
    for (int i = 0; i < NW; i++) send_frame(8'hA5, 1'b1);
    sync_check("a5");

    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
    send_frame(8'($urandom), 1'b0);
    idle(P);
    sync_check("bad_stop");
    for (int i = 0; i < NW; i++) send_frame(8'h11 + 8'(i), 1'b1);
    sync_check("after_bad_stop");

    send_frame(8'h5A, 1'b1);
    send_frame(8'hC3, 1'b1);
    sync_check("pre_timeout");
    idle(TOB * P + 1);
    sync_check("timeout");
    for (int i = 0; i < NW; i++) send_frame(8'hF0 + 8'(i), 1'b1);
    sync_check("after_timeout");

    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
    idle(40);
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
    sync_check("short_gap");

    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    rst = 1'b1;
    model_reset();
    wait_cycles(2);
    check("in_reset.q", Q, 64'd0);
    check("in_reset.finish", {63'd0, finish}, 64'd0);
    check("in_reset.busy", {63'd0, busy}, 64'd0);
    check("in_reset.frame_error", {63'd0, frameError}, 64'd0);
    rx = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(P);
    sync_check("post_reset");
    for (int i = 0; i < NW; i++) send_frame(8'h21 + 8'(i), 1'b1);
    sync_check("after_reset");

    f0 = fin_cyc.size();
    for (int i = 1; i <= 16; i++) send_frame(8'(i), 1'b1);
    sync_check("two_pkgs");
    check("two_pkgs.spacing",
          (fin_cyc.size() == f0 + 2) ? 64'(fin_cyc[f0 + 1] - fin_cyc[f0]) : 64'd0,
          64'(NW * (WW + 2) * P));

    send_frame(8'h77, 1'b1);
    rx = 1'b0;
    wait_cycles(12 * P);
    model_frame(8'h00, 1'b0);
    idle(P);
    sync_check("break");

    for (int k = 0; k < 6; k++) begin
      for (int w = 0; w < NW; w++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 11) == 0) begin
          send_frame(b, 1'b0);
          idle(P);
        end else begin
          send_frame(b, 1'b1);
        end
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 30));
      end
      sync_check("random");
    end

    idle(2 * P);
    sync_check("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
